mig_app_responder: RTL

// - Responder (slave) end of the DDR IP APP/UI interface: a BRAM-backed stand-in for the MIG core.
// - Lets the multiport VDMA run in simulation and board bring-up without DDR.
// - Accepts app_cmd/app_addr and write-data beats, executes commands strictly in order, returns read data after a fixed latency.
// - Models init calibration and optional app_rdy backpressure.

---
 rtl/mig_app_responder.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/mig_app_responder.sv
// mig_app_responder
// BRAM-backed responder for the DDR controller APP/UI interface. It stands in
// for the memory controller so the VDMA side can run without real DDR.
// Commands and write-data beats are queued separately and executed strictly in
// order, one command per cycle at most. Read data returns through a fixed-depth
// pipe. Calibration delay and optional app_rdy throttling are modelled.
//
// Ports
//   axi_aclk, axi_reset      clock, asynchronous active-high reset
//   app_addr/app_cmd/app_en  command channel (000 write, 001 read)
//   app_rdy                  command accepted when app_en & app_rdy
//   app_wdf_*                write-data channel, one beat per write command
//   app_wdf_rdy              beat accepted when app_wdf_wren & app_wdf_rdy
//   app_rd_data*             read return, one beat per read, no backpressure
//   init_calib_complete      sticky calibration-done flag
//   protocol_err             sticky: illegal command or beat without wdf_end
module mig_app_responder #(
    parameter int ASIZE        = 29,
    parameter int AXI_DSIZE    = 256,
    parameter int MEM_AW       = 10,
    parameter int ADDR_SHIFT   = 3,
    parameter int RD_LATENCY   = 4,
    parameter int CMDQ_DEPTH   = 8,
    parameter int WDF_DEPTH    = 8,
    parameter int CALIB_CYCLES = 64,
    parameter int RDY_GAP      = 0
) (
    input  logic                   axi_aclk,
    input  logic                   axi_reset,
    input  logic [ASIZE-1:0]       app_addr,
    input  logic [2:0]             app_cmd,
    input  logic                   app_en,
    input  logic [AXI_DSIZE-1:0]   app_wdf_data,
    input  logic                   app_wdf_end,
    input  logic [AXI_DSIZE/8-1:0] app_wdf_mask,
    input  logic                   app_wdf_wren,
    output logic [AXI_DSIZE-1:0]   app_rd_data,
    output logic                   app_rd_data_end,
    output logic                   app_rd_data_valid,
    output logic                   app_rdy,
    output logic                   app_wdf_rdy,
    output logic                   init_calib_complete,
    output logic                   protocol_err
);

    localparam int MW     = AXI_DSIZE / 8;
    localparam int CQ_AW  = $clog2(CMDQ_DEPTH);
    localparam int WQ_AW  = $clog2(WDF_DEPTH);
    localparam int CAL_W  = $clog2(CALIB_CYCLES + 1);
    localparam int GAP_N  = (RDY_GAP > 0) ? RDY_GAP : 1;
    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    typedef enum logic {S_IDLE, S_WAIT_WD} state_t;

    state_t state, state_next;

    logic [AXI_DSIZE-1:0] mem [2**MEM_AW];

    logic [2:0]        cq_cmd_mem  [CMDQ_DEPTH];
    logic [MEM_AW-1:0] cq_word_mem [CMDQ_DEPTH];
    logic [CQ_AW:0]    cq_wr, cq_rd;
    logic              cq_full, cq_empty, cq_push, cq_pop;
    logic [2:0]        head_cmd;
    logic [MEM_AW-1:0] head_word;

    logic [AXI_DSIZE-1:0] wd_data_mem [WDF_DEPTH];
    logic [MW-1:0]        wd_mask_mem [WDF_DEPTH];
    logic [WQ_AW:0]       wd_wr, wd_rd;
    logic                 wd_full, wd_empty, wd_push, wd_pop;

    logic rd_issue, wr_commit, illegal;

    logic [CAL_W-1:0] cal_cnt;
    logic [15:0]      gap_cnt;
    logic             throttle;

    logic [RD_LATENCY:0]  vld_p;
    logic [AXI_DSIZE-1:0] rd_data_p [RD_LATENCY+1];

    // Address bits outside the word index are deliberately ignored.
    logic addr_unused;
    assign addr_unused = ^app_addr;

    // Calibration: counts from reset release, then holds.
    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            cal_cnt             <= '0;
            init_calib_complete <= 1'b0;
        end else if (!init_calib_complete) begin
            cal_cnt <= cal_cnt + 1'b1;
            if (cal_cnt == CAL_W'(CALIB_CYCLES - 1))
                init_calib_complete <= 1'b1;
        end
    end

    // Free-running throttle: one blocked cycle out of every RDY_GAP.
    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset)
            gap_cnt <= '0;
        else if (gap_cnt == 16'(GAP_N - 1))
            gap_cnt <= '0;
        else
            gap_cnt <= gap_cnt + 1'b1;
    end
    assign throttle = (RDY_GAP > 0) && (gap_cnt == 16'(GAP_N - 1));

    assign cq_full  = (cq_wr[CQ_AW] != cq_rd[CQ_AW]) && (cq_wr[CQ_AW-1:0] == cq_rd[CQ_AW-1:0]);
    assign cq_empty = (cq_wr == cq_rd);
    assign wd_full  = (wd_wr[WQ_AW] != wd_rd[WQ_AW]) && (wd_wr[WQ_AW-1:0] == wd_rd[WQ_AW-1:0]);
    assign wd_empty = (wd_wr == wd_rd);

    assign app_rdy     = init_calib_complete & ~cq_full & ~throttle;
    assign app_wdf_rdy = init_calib_complete & ~wd_full;
    assign cq_push     = app_en & app_rdy;
    assign wd_push     = app_wdf_wren & app_wdf_rdy;

    assign head_cmd  = cq_cmd_mem[cq_rd[CQ_AW-1:0]];
    assign head_word = cq_word_mem[cq_rd[CQ_AW-1:0]];

    // Queue storage (no reset: contents are only meaningful between pointers).
    always_ff @(posedge axi_aclk) begin
        if (cq_push) begin
            cq_cmd_mem[cq_wr[CQ_AW-1:0]]  <= app_cmd;
            cq_word_mem[cq_wr[CQ_AW-1:0]] <= app_addr[ADDR_SHIFT +: MEM_AW];
        end
        if (wd_push) begin
            wd_data_mem[wd_wr[WQ_AW-1:0]] <= app_wdf_data;
            wd_mask_mem[wd_wr[WQ_AW-1:0]] <= app_wdf_mask;
        end
    end

    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            cq_wr <= '0;
            cq_rd <= '0;
            wd_wr <= '0;
            wd_rd <= '0;
        end else begin
            if (cq_push) cq_wr <= cq_wr + 1'b1;
            if (cq_pop)  cq_rd <= cq_rd + 1'b1;
            if (wd_push) wd_wr <= wd_wr + 1'b1;
            if (wd_pop)  wd_rd <= wd_rd + 1'b1;
        end
    end

    // Head-of-queue executor.
    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) state <= S_IDLE;
        else           state <= state_next;
    end

    always_comb begin
        state_next = state;
        cq_pop     = 1'b0;
        wd_pop     = 1'b0;
        rd_issue   = 1'b0;
        wr_commit  = 1'b0;
        illegal    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!cq_empty) begin
                    if (head_cmd == CMD_RD) begin
                        rd_issue = 1'b1;
                        cq_pop   = 1'b1;
                    end else if (head_cmd == CMD_WR) begin
                        if (!wd_empty) begin
                            wr_commit = 1'b1;
                            cq_pop    = 1'b1;
                            wd_pop    = 1'b1;
                        end else begin
                            state_next = S_WAIT_WD;
                        end
                    end else begin
                        cq_pop  = 1'b1;
                        illegal = 1'b1;
                    end
                end
            end
            S_WAIT_WD: begin
                if (!wd_empty) begin
                    wr_commit  = 1'b1;
                    cq_pop     = 1'b1;
                    wd_pop     = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset)
            protocol_err <= 1'b0;
        else if (illegal || (wd_push && !app_wdf_end))
            protocol_err <= 1'b1;
    end

    // Backing RAM: byte i is written only when its mask bit is 0.
    always_ff @(posedge axi_aclk) begin
        if (wr_commit) begin
            for (int i = 0; i < MW; i++) begin
                if (!wd_mask_mem[wd_rd[WQ_AW-1:0]][i])
                    mem[head_word][8*i +: 8] <= wd_data_mem[wd_rd[WQ_AW-1:0]][8*i +: 8];
            end
        end
    end

    // Read pipe stage p0: synchronous RAM read at issue; later stages delay it.
    always_ff @(posedge axi_aclk) begin
        rd_data_p[0] <= mem[head_word];
        for (int i = 1; i <= RD_LATENCY; i++)
            rd_data_p[i] <= rd_data_p[i-1];
    end

    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) vld_p <= '0;
        else           vld_p <= {vld_p[RD_LATENCY-1:0], rd_issue};
    end

    // Data is gated so every output reads 0 while idle or in reset.
    assign app_rd_data_valid = vld_p[RD_LATENCY];
    assign app_rd_data_end   = vld_p[RD_LATENCY];
    assign app_rd_data       = vld_p[RD_LATENCY] ? rd_data_p[RD_LATENCY] : '0;

endmodule
